// File: rtl/vector_mac_pkg.sv
// Shared geometry, internal widths and stage types for the streaming dot-product pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vector_mac_pkg;

  // Vector geometry of the GCN feature/weight columns
  localparam int ELEM_WIDTH = 5;
  localparam int LANES      = 12;
  localparam int VEC_LEN    = 96;

  // Full-precision internal widths; nothing is truncated before the output mapping
  localparam int PROD_W    = 2 * ELEM_WIDTH;
  localparam int LSUM_W    = PROD_W + $clog2(LANES);
  localparam int ACC_INT_W = PROD_W + $clog2(VEC_LEN);

  // Number of beats that make up one vector
  function automatic int beats_f(input int vec_len, input int lanes);
    return vec_len / lanes;
  endfunction

  localparam int BEATS = beats_f(VEC_LEN, LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Elaboration guard: a vector must split into whole beats
  localparam bit VEC_LEN_DIVISIBLE = ((VEC_LEN % LANES) == 0);

  // Per-lane product vector between S1 and the adder tree
  typedef logic [LANES-1:0][PROD_W-1:0] prod_vec_t;

  // Pipeline stage carrying a lane sum toward the accumulator
  typedef struct packed {
    logic              vld;
    logic              last;
    logic [LSUM_W-1:0] payload;
  } stage_t;

endpackage

// File: rtl/vector_mac_pipe_lane_adder_tree.sv
// Sums the LANES registered products of one beat into a single lane sum.
// Latency: combinational (sits between the S1 and S2 registers).
// Backpressure: none; the surrounding stage registers hold when the pipe stalls.
module lane_adder_tree
  import vector_mac_pkg::*;
(
  input  logic [LANES-1:0][PROD_W-1:0] i_prod,
  output logic [LSUM_W-1:0]            o_sum
);

  // Unsigned reduction at full LSUM_W precision; cannot overflow by construction
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      o_sum = o_sum + LSUM_W'(i_prod[i]);
    end
  end

endmodule

// File: rtl/vector_mac_pipe.sv
// Streaming dot product: VEC_LEN unsigned feature*weight pairs in BEATS beats of LANES, one result per vector.
// Latency: result valid 3 edges after the vector's last beat is accepted; one beat per cycle sustained.
// Backpressure: an unconsumed result freezes every stage and drops in_ready; clear still aborts while frozen.
module vector_mac_pipe
  import vector_mac_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [0:LANES-1][ELEM_WIDTH-1:0] feature_in,
  input  logic [0:LANES-1][ELEM_WIDTH-1:0] weight_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             dot_out,
  output logic                             overflow
);

  if (!VEC_LEN_DIVISIBLE) begin : g_len_check
    $error("vector_mac_pipe: VEC_LEN must be a multiple of LANES");
  end

  logic                             w_advance;
  logic                             w_accept;
  logic                             w_last_beat;
  logic [CNT_W-1:0]                 r_beat_cnt;

  // S0: captured operands, keeps the multipliers off the input ports
  logic                             r_s0_vld;
  logic                             r_s0_last;
  logic [0:LANES-1][ELEM_WIDTH-1:0] r_s0_feat;
  logic [0:LANES-1][ELEM_WIDTH-1:0] r_s0_wt;

  // S1: per-lane products
  prod_vec_t                        w_prod;
  prod_vec_t                        r_s1_prod;
  logic                             r_s1_vld;
  logic                             r_s1_last;

  // S2: lane sum of one beat
  logic [LSUM_W-1:0]                w_lane_sum;
  stage_t                           r_s2;

  // S3: accumulator and held result
  logic [ACC_INT_W-1:0]             r_acc;
  logic [ACC_INT_W-1:0]             w_acc_sum;
  logic [ACC_WIDTH-1:0]             w_dot_map;
  logic                             w_ovf;
  logic                             r_out_vld;
  logic [ACC_WIDTH-1:0]             r_dot;
  logic                             r_ovf;

  assign w_advance   = !r_out_vld || out_ready;
  assign in_ready    = w_advance && !clear && rst_n;
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

  assign out_valid = r_out_vld;
  assign dot_out   = r_dot;
  assign overflow  = r_ovf;

  // Beat position within the current vector; the only source of vector boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (clear) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
    end
  end

  // S0: register the accepted beat and tag the vector's final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_vld  <= 1'b0;
      r_s0_last <= 1'b0;
      r_s0_feat <= '0;
      r_s0_wt   <= '0;
    end else if (clear) begin
      r_s0_vld  <= 1'b0;
      r_s0_last <= 1'b0;
    end else if (w_advance) begin
      r_s0_vld  <= w_accept;
      r_s0_last <= w_accept && w_last_beat;
      if (w_accept) begin
        r_s0_feat <= feature_in;
        r_s0_wt   <= weight_in;
      end
    end
  end

  // Lane multipliers at full PROD_W precision
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = PROD_W'(r_s0_feat[i]) * PROD_W'(r_s0_wt[i]);
    end
  end

  // S1: register the products; payload only moves with a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_prod <= '0;
    end else if (clear) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
    end else if (w_advance) begin
      r_s1_vld  <= r_s0_vld;
      r_s1_last <= r_s0_last;
      if (r_s0_vld) begin
        r_s1_prod <= w_prod;
      end
    end
  end

  lane_adder_tree u_lane_adder_tree (
    .i_prod (r_s1_prod),
    .o_sum  (w_lane_sum)
  );

  // S2: register the reduced lane sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= '0;
    end else if (clear) begin
      r_s2.vld  <= 1'b0;
      r_s2.last <= 1'b0;
    end else if (w_advance) begin
      r_s2.vld  <= r_s1_vld;
      r_s2.last <= r_s1_last;
      if (r_s1_vld) begin
        r_s2.payload <= w_lane_sum;
      end
    end
  end

  assign w_acc_sum = r_acc + ACC_INT_W'(r_s2.payload);

  // Map the full-precision sum onto the output width
  if (ACC_INT_W > ACC_WIDTH) begin : g_narrow
    assign w_ovf     = |w_acc_sum[ACC_INT_W-1:ACC_WIDTH];
    assign w_dot_map = (SATURATE && w_ovf) ? {ACC_WIDTH{1'b1}} : w_acc_sum[ACC_WIDTH-1:0];
  end else begin : g_wide
    assign w_ovf     = 1'b0;
    assign w_dot_map = ACC_WIDTH'(w_acc_sum);
  end

  // S3: accumulate beats; restart from zero once the last beat is folded in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (w_advance && r_s2.vld) begin
      r_acc <= r_s2.last ? '0 : w_acc_sum;
    end
  end

  // Result register: loads on vector completion (even while the previous one is consumed), clears on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_dot     <= '0;
      r_ovf     <= 1'b0;
    end else if (w_advance && !clear && r_s2.vld && r_s2.last) begin
      r_out_vld <= 1'b1;
      r_dot     <= w_dot_map;
      r_ovf     <= w_ovf;
    end else if (r_out_vld && out_ready) begin
      r_out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vector_mac_pipe.sv
// Self-checking bench: wrap and saturate instances share stimulus, results checked from a scoreboard queue.
// Latency: checks result latency of 3 edges after the last accepted beat.
// Backpressure: exercises output stalls, clear while stalled and async reset mid-vector.
`timescale 1ns/1ps
module tb_vector_mac_pipe;
  import vector_mac_pkg::*;

  typedef logic [0:LANES-1][ELEM_WIDTH-1:0] lanes_t;

  typedef struct {
    int wrap;
    int sat;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  lanes_t      feature_in = '0;
  lanes_t      weight_in = '0;
  logic        in_ready_w, in_ready_s;
  logic        out_valid_w, out_valid_s;
  logic        ovf_w, ovf_s;
  logic [15:0] dot_w, dot_s;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_accept_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vector_mac_pipe #(.ACC_WIDTH(16), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_w),
    .feature_in(feature_in), .weight_in(weight_in), .out_valid(out_valid_w),
    .out_ready(out_ready), .dot_out(dot_w), .overflow(ovf_w)
  );

  vector_mac_pipe #(.ACC_WIDTH(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
    .feature_in(feature_in), .weight_in(weight_in), .out_valid(out_valid_s),
    .out_ready(out_ready), .dot_out(dot_s), .overflow(ovf_s)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input int sum);
    exp_t e;
    e.ovf  = (sum > 65535);
    e.wrap = sum & 32'h0000_FFFF;
    e.sat  = e.ovf ? 65535 : sum;
    return e;
  endfunction

  // Scoreboard: a result is consumed on the next edge whenever valid and ready are both seen here
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid_w && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", dot_w, -1);
      end else begin
        mon_e = exp_q.pop_front();
        check("dot_wrap", dot_w, mon_e.wrap);
        check("ovf_wrap", ovf_w, mon_e.ovf);
        check("vld_sat", out_valid_s, 1);
        check("dot_sat", dot_s, mon_e.sat);
        check("ovf_sat", ovf_s, mon_e.ovf);
      end
    end
  end

  task automatic send_beat(input lanes_t f, input lanes_t w);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    feature_in = f;
    weight_in  = w;
    #1;
    while (!in_ready_w && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_ready_w) check("in_ready_timeout", in_ready_w, 1);
    @(posedge clk);
    #1;
    last_accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_vector(input int f, input int w, input bit rnd);
    lanes_t fv, wv;
    int sum;
    sum = 0;
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        fv[l] = rnd ? ELEM_WIDTH'($urandom_range(0, 31)) : ELEM_WIDTH'(f);
        wv[l] = rnd ? ELEM_WIDTH'($urandom_range(0, 31)) : ELEM_WIDTH'(w);
        sum += int'(fv[l]) * int'(wv[l]);
      end
      send_beat(fv, wv);
    end
    exp_q.push_back(make_exp(sum));
  endtask

  task automatic send_uniform_beats(input int n, input int v);
    lanes_t fv;
    for (int l = 0; l < LANES; l++) fv[l] = ELEM_WIDTH'(v);
    for (int b = 0; b < n; b++) send_beat(fv, fv);
  endtask

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid_w && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid_w) check(tag, out_valid_w, 1);
  endtask

  task automatic drain(input string tag);
    repeat (12) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_cyc;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid_w, 0);
    check("rst_dot", dot_w, 0);
    check("rst_ovf", ovf_w, 0);
    check("rst_in_ready", in_ready_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready_w, 1);

    // All-ones vector and its latency
    send_vector(1, 1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("latency_t2", out_valid_w, 0);
    @(negedge clk);
    #1;
    check("latency_t3", out_valid_w, 1);
    drain("drain_ones");

    // All-31: wrap instance 26720, saturating instance 65535, both flag overflow
    send_vector(31, 31, 1'b0);
    drain("drain_max");

    // Stall after vector A; B waits without loss
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send_vector(1, 1, 1'b0);
        send_vector(2, 3, 1'b0);
      end
      begin
        wait_out_valid("stall_wait_a");
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          check("stall_in_ready", in_ready_w, 0);
          check("stall_hold_vld", out_valid_w, 1);
          check("stall_hold_dot", dot_w, 96);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Clear while stalled aborts in-flight beats but keeps the held result
    @(negedge clk);
    out_ready = 1'b0;
    send_vector(2, 1, 1'b0);
    send_uniform_beats(3, 31);
    wait_out_valid("clr_stall_wait");
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check("clr_keep_vld", out_valid_w, 1);
    check("clr_keep_dot", dot_w, 192);
    @(negedge clk);
    out_ready = 1'b1;
    send_vector(1, 1, 1'b0);
    drain("drain_clr_stall");

    // Three beats then clear with a beat presented; that beat is refused
    send_uniform_beats(3, 31);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("clr_in_ready", in_ready_w, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    send_vector(1, 1, 1'b0);
    drain("drain_clr");

    // Async reset drops a held result without a clock edge
    @(negedge clk);
    out_ready = 1'b0;
    send_vector(1, 1, 1'b0);
    wait_out_valid("rst_hold_wait");
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", out_valid_w, 0);
    check("async_rst_dot", dot_w, 0);
    check("async_rst_in_ready", in_ready_w, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Reset after five beats; the next vector starts fresh
    send_uniform_beats(5, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid_w, 0);
    check("mid_rst_dot", dot_w, 0);
    check("mid_rst_ovf", ovf_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_vector(1, 1, 1'b0);
    drain("drain_rst");

    // Back-to-back streaming: no bubbles, every result in order
    send_vector(0, 0, 1'b1);
    first_cyc = last_accept_cyc - (BEATS - 1);
    send_vector(31, 31, 1'b0);
    send_vector(2, 3, 1'b0);
    send_vector(0, 0, 1'b1);
    check("stream_cycles", last_accept_cyc - first_cyc, 4 * BEATS - 1);
    drain("drain_stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
